// File: rtl/exception_ctrl_if.sv
// Bundles the EX/ID status inputs and the pipeline-control outputs of exception_ctrl.
// slave = exception controller side, master = pipeline/hazard side.
interface exception_ctrl_if #(
    parameter int AW = 16
);
    logic          over_flow;
    logic [AW-1:0] ex_pc;
    logic          eret;
    logic          exc_enable;

    logic          if_id_flash;
    logic          id_ex_flash;
    logic          ex_mem_flash;
    logic          pc_write;
    logic          redirect_valid;
    logic [AW-1:0] pc_redirect;
    logic [AW-1:0] epc;
    logic          in_handler;
    logic [7:0]    exc_count;
    logic [7:0]    drop_count;

    modport slave (
        input  over_flow, ex_pc, eret, exc_enable,
        output if_id_flash, id_ex_flash, ex_mem_flash, pc_write, redirect_valid,
               pc_redirect, epc, in_handler, exc_count, drop_count
    );

    modport master (
        output over_flow, ex_pc, eret, exc_enable,
        input  if_id_flash, id_ex_flash, ex_mem_flash, pc_write, redirect_valid,
               pc_redirect, epc, in_handler, exc_count, drop_count
    );
endinterface

// File: rtl/exception_ctrl.sv
// Overflow exception sequencer: flush, redirect to handler vector, return to EPC+4.
// Latency: 2 cycles overflow-edge to redirect, 1 cycle ERET-edge to return; no backpressure.
module exception_ctrl #(
    parameter int            AW           = 16,
    parameter logic [AW-1:0] HANDLER_ADDR = 16'h0040
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    exception_ctrl_if.slave io_exc
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FLUSH,
        ST_REDIRECT,
        ST_HANDLER,
        ST_RETURN
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_epc;
    logic [7:0]    r_exc_count;
    logic [7:0]    r_drop_count;
    logic [2:0]    r_flush;        // {if_id, id_ex, ex_mem}
    logic          r_pc_write;
    logic          r_redir_vld;
    logic [AW-1:0] r_pc_redirect;
    logic          r_in_handler;

    wire w_ovf = io_exc.over_flow & io_exc.exc_enable;

    // Outputs are registered against the destination state, so they are a pure
    // function of the state visible in the same cycle.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state       <= ST_IDLE;
            r_epc         <= '0;
            r_exc_count   <= 8'd0;
            r_drop_count  <= 8'd0;
            r_flush       <= 3'b000;
            r_pc_write    <= 1'b1;
            r_redir_vld   <= 1'b0;
            r_pc_redirect <= '0;
            r_in_handler  <= 1'b0;
        end else begin
            r_flush       <= 3'b000;
            r_pc_write    <= 1'b1;
            r_redir_vld   <= 1'b0;
            r_pc_redirect <= '0;
            r_in_handler  <= 1'b0;

            if (w_ovf && (r_state != ST_IDLE) && (r_drop_count != 8'hFF))
                r_drop_count <= r_drop_count + 8'd1;

            case (r_state)
                ST_IDLE: begin
                    if (w_ovf) begin
                        r_state     <= ST_FLUSH;
                        r_epc       <= io_exc.ex_pc;
                        r_exc_count <= r_exc_count + 8'd1;
                        r_flush     <= 3'b111;
                        r_pc_write  <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    r_state       <= ST_REDIRECT;
                    r_redir_vld   <= 1'b1;
                    r_pc_redirect <= HANDLER_ADDR;
                    r_flush       <= 3'b100;
                end
                ST_REDIRECT: begin
                    r_state      <= ST_HANDLER;
                    r_in_handler <= 1'b1;
                end
                ST_HANDLER: begin
                    r_in_handler <= 1'b1;
                    if (io_exc.eret) begin
                        r_state       <= ST_RETURN;
                        r_redir_vld   <= 1'b1;
                        r_pc_redirect <= r_epc + AW'(4);
                        r_flush       <= 3'b100;
                    end
                end
                ST_RETURN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign io_exc.if_id_flash    = r_flush[2];
    assign io_exc.id_ex_flash    = r_flush[1];
    assign io_exc.ex_mem_flash   = r_flush[0];
    assign io_exc.pc_write       = r_pc_write;
    assign io_exc.redirect_valid = r_redir_vld;
    assign io_exc.pc_redirect    = r_pc_redirect;
    assign io_exc.epc            = r_epc;
    assign io_exc.in_handler     = r_in_handler;
    assign io_exc.exc_count      = r_exc_count;
    assign io_exc.drop_count     = r_drop_count;
endmodule

// File: doc/exception_ctrl.md
# exception_ctrl

Sequences the pipeline through an arithmetic-overflow exception and the matching return. On an enabled overflow from EX it captures the faulting PC, flushes the pipeline, and redirects fetch to a fixed handler vector. On ERET it redirects fetch to EPC+4. It sits beside the hazard unit: its flush and PC-hold outputs are ORed/ANDed into the pipeline-register controls, and its redirect port feeds the PC mux at top priority.

## Interface
- AW, 16, PC/address width
- HANDLER_ADDR, 16'h0040, handler vector (AW bits)
- CLK  in  1  clock, all state updates on rising edge
- RST_N  in  1  synchronous, active-low reset
- OVER_FLOW  in  1  overflow flag of the instruction currently in EX
- EX_PC  in  AW  PC of the instruction currently in EX
- ERET  in  1  return-from-exception decoded in ID
- EXC_ENABLE  in  1  overflow exceptions enabled
- IF_ID_FLASH  out  1  flush IF/ID register
- ID_EX_FLASH  out  1  flush ID/EX register
- EX_MEM_FLASH  out  1  flush EX/MEM register, killing the faulting instruction
- PC_WRITE  out  1  0 = hold PC
- REDIRECT_VALID  out  1  load PC from PC_REDIRECT this cycle
- PC_REDIRECT  out  AW  redirect target
- EPC  out  AW  captured faulting PC
- IN_HANDLER  out  1  handler code executing
- EXC_COUNT  out  8  exceptions taken, wraps 255→0
- DROP_COUNT  out  8  overflows dropped while busy, saturates at 255

## Operation
- Moore FSM with states IDLE, FLUSH, REDIRECT, HANDLER, RETURN. Outputs decode from state only. EPC and both counters are registers.
- IDLE: if OVER_FLOW && EXC_ENABLE, go to FLUSH, set EPC ← EX_PC, and EXC_COUNT += 1. Otherwise stay in IDLE. ERET in IDLE is ignored.
- FLUSH: all three flush outputs = 1, PC_WRITE = 0. Unconditionally go to REDIRECT.
- REDIRECT: REDIRECT_VALID = 1, PC_REDIRECT = HANDLER_ADDR, IF_ID_FLASH = 1, PC_WRITE = 1. Go to HANDLER.
- HANDLER: IN_HANDLER = 1, all other controls at default. ERET moves to RETURN.
- RETURN: REDIRECT_VALID = 1, PC_REDIRECT = EPC + 4 (mod 2^AW, carry discarded), IF_ID_FLASH = 1, IN_HANDLER = 1. Go to IDLE.
- Defaults, in IDLE and wherever not stated above: flushes 0, PC_WRITE 1, REDIRECT_VALID 0, PC_REDIRECT 0, IN_HANDLER 0.
- Nesting is not supported. OVER_FLOW && EXC_ENABLE while in FLUSH, REDIRECT, HANDLER or RETURN increments DROP_COUNT (saturating) and has no other effect. EPC is never overwritten outside IDLE.
- OVER_FLOW with EXC_ENABLE = 0 is ignored in every state and is not counted.
- OVER_FLOW and ERET in the same HANDLER cycle: ERET is honoured (go to RETURN) and the overflow is counted as dropped.
- EPC holds its value after return until the next exception is taken.

## Timing
- Reset (RST_N = 0 at an edge): state IDLE, EPC = 0, EXC_COUNT = 0, DROP_COUNT = 0. All outputs take their IDLE defaults from the next cycle.
- Reset overrides every state, including mid-FLUSH or mid-HANDLER. No redirect is issued on reset exit.
- Overflow sampled at edge t gives the following sequence:
  - FLUSH during cycle t+1.
  - REDIRECT during t+2.
  - HANDLER from t+3.
  - First handler fetch address is HANDLER_ADDR in cycle t+3.
- ERET sampled at edge u gives RETURN during u+1 and IDLE from u+2. The first post-return fetch is EPC+4 in cycle u+2.
- Exception entry latency: 2 cycles from the overflow edge to the redirect cycle. Return latency: 1 cycle.
- EPC and EXC_COUNT update on the same edge that enters FLUSH, so both are visible in cycle t+1.

## Test plan
- Reset, then idle: check PC_WRITE = 1, all flushes 0, REDIRECT_VALID = 0, EPC = 0, and both counters 0.
- OVER_FLOW = 1, EXC_ENABLE = 1, EX_PC = 16'h0120: check
  - next cycle: flushes = 111, PC_WRITE = 0, EPC = 16'h0120, EXC_COUNT = 1;
  - following cycle: REDIRECT_VALID = 1, PC_REDIRECT = 16'h0040;
  - then IN_HANDLER = 1.
- In HANDLER, pulse ERET: check the next cycle has REDIRECT_VALID = 1 and PC_REDIRECT = 16'h0124, then IDLE with IN_HANDLER = 0. Repeat with EPC = 16'hFFFE and check PC_REDIRECT = 16'h0002.
- In HANDLER, pulse OVER_FLOW 300 times: check EPC unchanged, DROP_COUNT = 255, EXC_COUNT unchanged. Then assert OVER_FLOW and ERET together: check RETURN is taken.
- OVER_FLOW with EXC_ENABLE = 0: check no state change and no count.
- Assert RST_N = 0 during FLUSH: check IDLE defaults on the next cycle, EPC = 0, and no redirect.
